// File: rtl/id_pipe_stage.sv
// rtl/id_pipe_stage.sv - RV32I/E decode stage: register file, decoder and ID/EX register
// Optional macro ID_BYPASS_EN makes register-file reads write-first.
module id_pipe_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_fn3,
   output logic            out_fn7_5,
   output logic [2:0]      out_aluop,
   output logic            out_alu_src,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_reg_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic [1:0]      out_memtoreg,
   output logic            out_illegal
);
   localparam int         IW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
   logic            legal_op, uses_rs1, uses_rs2, illegal, stall_lu;
   logic [2:0]      d_aluop;
   logic [1:0]      d_memtoreg;
   logic            d_alu_src, d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump;

   function automatic logic in_range(input logic [4:0] idx);
      return {1'b0, idx} < NREGS_L;
   endfunction

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   // x0 is never written, so reading regs[0] always yields zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0 && in_range(wb_rd)) begin
         regs[wb_rd[IW-1:0]] <= wb_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (in_range(rs1)) rs1_data = regs[rs1[IW-1:0]];
      if (in_range(rs2)) rs2_data = regs[rs2[IW-1:0]];
`ifdef ID_BYPASS_EN
      if (wb_en && wb_rd == rs1 && rs1 != 5'd0) rs1_data = wb_data;
      if (wb_en && wb_rd == rs2 && rs2 != 5'd0) rs2_data = wb_data;
`endif
   end

   always_comb begin
      legal_op    = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      imm32       = '0;
      d_aluop     = 3'b000;
      d_alu_src   = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_reg_write = 1'b0;
      d_branch    = 1'b0;
      d_jump      = 1'b0;
      d_memtoreg  = 2'b00;
      case (opcode)
         OP_LUI:    begin imm32 = imm_u; d_aluop = 3'b100; d_alu_src = 1'b1; d_reg_write = 1'b1; end
         OP_AUIPC:  begin imm32 = imm_u; d_alu_src = 1'b1; d_reg_write = 1'b1; end
         OP_JAL:    begin imm32 = imm_j; d_alu_src = 1'b1; d_reg_write = 1'b1; d_jump = 1'b1; d_memtoreg = 2'b10; end
         OP_JALR:   begin imm32 = imm_i; uses_rs1 = 1'b1; d_alu_src = 1'b1; d_reg_write = 1'b1; d_jump = 1'b1; d_memtoreg = 2'b10; end
         OP_BRANCH: begin imm32 = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; d_aluop = 3'b001; d_branch = 1'b1; end
         OP_LOAD:   begin imm32 = imm_i; uses_rs1 = 1'b1; d_alu_src = 1'b1; d_mem_read = 1'b1; d_reg_write = 1'b1; d_memtoreg = 2'b01; end
         OP_STORE:  begin imm32 = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1; d_alu_src = 1'b1; d_mem_write = 1'b1; end
         OP_IMM:    begin imm32 = imm_i; uses_rs1 = 1'b1; d_aluop = 3'b011; d_alu_src = 1'b1; d_reg_write = 1'b1; end
         OP_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; d_aluop = 3'b010; d_reg_write = 1'b1; end
         default:   legal_op = 1'b0;
      endcase
   end

   // Only indices the instruction actually uses can make it illegal
   assign illegal = !legal_op || (uses_rs1 && !in_range(rs1)) || (uses_rs2 && !in_range(rs2))
                    || (d_reg_write && !in_range(rd));

   assign stall_lu = out_valid && out_mem_read && out_rd != 5'd0 &&
                     ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));

   assign in_ready = !reset && (!out_valid || ex_ready) && !stall_lu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_rs1_data  <= '0;
         out_rs2_data  <= '0;
         out_imm       <= '0;
         out_rs1       <= '0;
         out_rs2       <= '0;
         out_rd        <= '0;
         out_fn3       <= '0;
         out_fn7_5     <= 1'b0;
         out_aluop     <= '0;
         out_alu_src   <= 1'b0;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         out_reg_write <= 1'b0;
         out_branch    <= 1'b0;
         out_jump      <= 1'b0;
         out_memtoreg  <= '0;
         out_illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (!out_valid || ex_ready) begin
         out_valid <= in_valid && !stall_lu;
         if (in_valid && in_ready) begin
            out_pc        <= in_pc;
            out_rs1_data  <= rs1_data;
            out_rs2_data  <= rs2_data;
            out_imm       <= XLEN'($signed(imm32));
            out_rs1       <= rs1;
            out_rs2       <= rs2;
            out_rd        <= rd;
            out_fn3       <= in_instr[14:12];
            out_fn7_5     <= in_instr[30];
            out_aluop     <= d_aluop;
            out_alu_src   <= d_alu_src;
            out_mem_read  <= d_mem_read && !illegal;
            out_mem_write <= d_mem_write && !illegal;
            out_reg_write <= d_reg_write && !illegal;
            out_branch    <= d_branch && !illegal;
            out_jump      <= d_jump && !illegal;
            out_memtoreg  <= d_memtoreg;
            out_illegal   <= illegal;
         end
      end
   end
endmodule
